// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI initiator for single RW/ADDR/DATA register frames
// One frame per accepted start, any CPOL/CPHA; miso is resynchronized before sampling.
module spi_master_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FRAME = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [DIV_W-1:0]       r_div;
  logic [BIT_W-1:0]       r_bit;
  logic                   r_phase;
  logic                   r_cpol;
  logic                   r_cpha;
  logic [FRAME-1:0]       r_tx;
  logic [REG_WIDTH-1:0]   r_rx;
  logic                   r_miso_s1;
  logic                   r_miso_s2;
  logic                   r_cs_n;
  logic                   r_sclk;
  logic                   r_mosi;
  logic                   r_busy;
  logic                   r_done;
  logic [REG_WIDTH-1:0]   r_rdata;

  logic                   w_tick;
  logic                   w_accept;
  logic                   w_edge;
  logic                   w_final;
  logic                   w_sample;
  logic                   w_shift;
  logic                   w_shift_bit;
  logic                   w_finish;

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign spi_cs_n = r_cs_n;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)          w_next = S_SETUP;
      S_SETUP: if (w_tick)            w_next = S_SHIFT;
      S_SHIFT: if (w_edge && w_final) w_next = S_HOLD;
      S_HOLD:  if (w_finish)          w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  // r_phase is 0 while waiting for a leading edge and 1 while waiting for a trailing edge.
  always_comb begin
    w_tick      = ena && (r_div == DIV_LAST);
    w_accept    = ena && start && !r_done && (r_state == S_IDLE);
    w_edge      = w_tick && ((r_state == S_SETUP) || (r_state == S_SHIFT));
    w_final     = r_phase && (r_bit == BIT_LAST);
    w_sample    = w_edge && (r_phase == r_cpha);
    w_shift     = w_edge && (r_cpha ? !r_phase : (r_phase && !w_final));
    w_shift_bit = r_cpha ? r_tx[FRAME-1] : r_tx[FRAME-2];
    w_finish    = w_tick && (r_state == S_HOLD);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_phase   <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
    end else if (ena) begin
      r_miso_s1 <= spi_miso;
      r_miso_s2 <= r_miso_s1;
      r_done    <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div  <= '0;
        r_cpol <= mode[1];
        if (w_accept) begin
          r_cpha  <= mode[0];
          r_sclk  <= mode[1];
          r_tx    <= {rw, addr, rw ? wdata : {REG_WIDTH{1'b0}}};
          r_mosi  <= mode[0] ? 1'b0 : rw;
          r_bit   <= '0;
          r_phase <= 1'b0;
          r_cs_n  <= 1'b0;
          r_busy  <= 1'b1;
        end else begin
          r_sclk <= r_cpol;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_edge) begin
          r_sclk  <= ~r_sclk;
          r_phase <= ~r_phase;
          if (r_phase && (r_bit != BIT_LAST)) begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        if (w_sample) begin
          r_rx <= {r_rx[REG_WIDTH-2:0], r_miso_s2};
        end
        if (w_shift) begin
          r_mosi <= w_shift_bit;
          r_tx   <= r_tx << 1;
        end
        if (w_finish) begin
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_rdata <= r_rx;
          r_sclk  <= r_cpol;
          r_mosi  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - randomized self-checking bench for spi_master_ctrl
// A behavioural slave serves a register map held in the bench and records what it receives.
module tb_spi_master_ctrl;

  localparam int CLK_DIV = 4;
  localparam int NBITS   = 16;
  localparam int LAT     = 1 + (2 * NBITS + 1) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic [1:0] mode;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  int n_pass   = 0;
  int n_checks = 0;

  spi_master_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(7), .REG_WIDTH(8)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .mode     (mode),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  // Register map: 0..7 plain config regs, 8 = ALU result from regs 0,1,2, everything else reads 0.
  logic [7:0] m_regs [0:7];

  function automatic logic [7:0] m_read(input logic [6:0] a);
    logic [7:0] x, y, c;
    if (a < 7'd8) return m_regs[a[2:0]];
    if (a == 7'd8) begin
      x = m_regs[0];
      y = m_regs[1];
      c = m_regs[2];
      if ((c[3:0] == 4'b1001) && !c[4]) return x + y + {7'd0, c[5]};
      return x ^ y;
    end
    return 8'h00;
  endfunction

  function automatic void m_write(input logic r, input logic [6:0] a, input logic [7:0] d);
    if (r && (a < 7'd8)) m_regs[a[2:0]] = d;
  endfunction

  // Slave: counts SCLK edges while selected, captures mosi on its sample edges, drives miso word MSB first.
  logic [15:0] s_txword = 16'h0000;
  logic [15:0] s_rx     = 16'h0000;
  logic        s_cpha   = 1'b0;
  logic        s_prev_clk = 1'b0;
  logic        s_prev_cs  = 1'b1;
  int          s_edges  = 0;
  int          s_samples = 0;
  int          s_last_edges = 0;
  int          s_last_samples = 0;
  int          s_frames = 0;
  int          s_idx = 0;

  always @(spi_clk or spi_cs_n) begin
    if (spi_cs_n !== s_prev_cs) begin
      if (spi_cs_n === 1'b0) begin
        s_edges   = 0;
        s_samples = 0;
        s_frames++;
      end else begin
        s_last_edges   = s_edges;
        s_last_samples = s_samples;
      end
      s_prev_cs = spi_cs_n;
    end else if ((spi_cs_n === 1'b0) && (spi_clk !== s_prev_clk)) begin
      if ((s_edges % 2) == int'(s_cpha)) begin
        s_rx = {s_rx[14:0], spi_mosi};
        s_samples++;
      end
      s_edges++;
    end
    s_prev_clk = spi_clk;
    if (!s_cpha) s_idx = s_edges / 2;
    else         s_idx = (s_edges == 0) ? 0 : (s_edges - 1) / 2;
    if (s_idx > 15) s_idx = 15;
    spi_miso = (spi_cs_n === 1'b0) ? s_txword[15 - s_idx] : 1'b0;
  end

  task automatic do_frame(input logic [1:0] m, input logic r, input logic [6:0] a, input logic [7:0] d,
                          input int stall_at, input int stall_len,
                          output int lat, output logic [7:0] exp_rd, output logic t1_ok);
    exp_rd   = m_read(a);
    s_txword = {8'($urandom), exp_rd};
    s_cpha   = m[0];
    mode     = m;
    repeat (2) @(posedge clk);
    #1;
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t1_ok = (busy === 1'b1) && (spi_cs_n === 1'b0);
    mode = 2'($urandom); rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    lat = 1;
    while ((done !== 1'b1) && (lat < 600)) begin
      if (lat == stall_at) ena = 1'b0;
      if (lat == stall_at + stall_len) ena = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    ena = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    ena = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; mode = 2'b00;
    rstb = 1'b1;
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (spi_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b expected 1", spi_cs_n); else n_pass++;
    n_checks++; if (spi_clk !== 1'b0) $display("FAIL rst_sclk: got %b expected 0", spi_clk); else n_pass++;
    n_checks++; if (spi_mosi !== 1'b0) $display("FAIL rst_mosi: got %b expected 0", spi_mosi); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", rdata); else n_pass++;
    mode = 2'b10;
    rstb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (spi_clk !== 1'b1) $display("FAIL idle_cpol1: got %b expected 1", spi_clk); else n_pass++;
    mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (spi_clk !== 1'b0) $display("FAIL idle_cpol0: got %b expected 0", spi_clk); else n_pass++;
  endtask

  task automatic test_write_mode0();
    int lat; logic [7:0] exp_rd; logic t1;
    do_frame(2'b00, 1'b1, 7'd0, 8'hA5, 0, 0, lat, exp_rd, t1);
    n_checks++; if (!t1) $display("FAIL wr0_t1: busy %b cs_n %b expected busy=1 cs_n=0 at T+1", busy, spi_cs_n); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL wr0_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_checks++; if (s_rx !== 16'h80A5) $display("FAIL wr0_mosi: got %h expected 80a5", s_rx); else n_pass++;
    n_checks++; if (s_last_samples != 16) $display("FAIL wr0_rising: got %0d expected 16", s_last_samples); else n_pass++;
    n_checks++; if (s_last_edges != 32) $display("FAIL wr0_edges: got %0d expected 32", s_last_edges); else n_pass++;
    n_checks++; if ((busy !== 1'b0) || (spi_cs_n !== 1'b1)) $display("FAIL wr0_end: busy %b cs_n %b expected 0/1", busy, spi_cs_n); else n_pass++;
    n_checks++; if (rdata !== exp_rd) $display("FAIL wr0_echo: got %h expected %h", rdata, exp_rd); else n_pass++;
    m_write(1'b1, 7'd0, 8'hA5);
    do_frame(2'b00, 1'b0, 7'd0, 8'h00, 0, 0, lat, exp_rd, t1);
    n_checks++; if (rdata !== 8'hA5) $display("FAIL rd0_data: got %h expected a5", rdata); else n_pass++;
  endtask

  task automatic test_modes();
    int lat; logic [7:0] exp_rd; logic t1;
    for (int m = 1; m < 4; m++) begin
      do_frame(2'(m), 1'b1, 7'd1, 8'h3C, 0, 0, lat, exp_rd, t1);
      n_checks++; if (lat != LAT) $display("FAIL mode%0d_latency: got %0d expected %0d", m, lat, LAT); else n_pass++;
      n_checks++; if (s_rx !== 16'h813C) $display("FAIL mode%0d_mosi: got %h expected 813c", m, s_rx); else n_pass++;
      n_checks++; if (s_last_samples != 16) $display("FAIL mode%0d_samples: got %0d expected 16", m, s_last_samples); else n_pass++;
      m_write(1'b1, 7'd1, 8'h3C);
      do_frame(2'(m), 1'b0, 7'd1, 8'h00, 0, 0, lat, exp_rd, t1);
      n_checks++; if (rdata !== 8'h3C) $display("FAIL mode%0d_read: got %h expected 3c", m, rdata); else n_pass++;
      n_checks++; if (s_rx !== 16'h0100) $display("FAIL mode%0d_rdframe: got %h expected 0100", m, s_rx); else n_pass++;
      m_regs[1] = 8'h00;
      do_frame(2'(m), 1'b1, 7'd1, 8'h00, 0, 0, lat, exp_rd, t1);
    end
  endtask

  task automatic test_loopback();
    int lat; logic [7:0] exp_rd; logic t1;
    do_frame(2'b00, 1'b1, 7'd0, 8'h07, 0, 0, lat, exp_rd, t1); m_write(1'b1, 7'd0, 8'h07);
    do_frame(2'b00, 1'b1, 7'd1, 8'h01, 0, 0, lat, exp_rd, t1); m_write(1'b1, 7'd1, 8'h01);
    do_frame(2'b00, 1'b1, 7'd2, 8'h09, 0, 0, lat, exp_rd, t1); m_write(1'b1, 7'd2, 8'h09);
    do_frame(2'b00, 1'b0, 7'd8, 8'h00, 0, 0, lat, exp_rd, t1);
    n_checks++; if (rdata !== 8'h08) $display("FAIL loop_alu: got %h expected 08", rdata); else n_pass++;
    n_checks++; if (s_rx !== 16'h0800) $display("FAIL loop_frame: got %h expected 0800", s_rx); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic [7:0] exp_rd; logic t1;
    logic [1:0] m; logic r; logic [6:0] a; logic [7:0] d; logic [15:0] exp_f;
    for (int i = 0; i < 10; i++) begin
      m = 2'($urandom); r = 1'($urandom); a = 7'($urandom_range(0, 9)); d = 8'($urandom);
      exp_f = {r, a, r ? d : 8'h00};
      do_frame(m, r, a, d, 0, 0, lat, exp_rd, t1);
      n_checks++; if (!t1) $display("FAIL rnd%0d_t1: busy %b cs_n %b expected 1/0", i, busy, spi_cs_n); else n_pass++;
      n_checks++; if (lat != LAT) $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, LAT); else n_pass++;
      n_checks++; if (s_rx !== exp_f) $display("FAIL rnd%0d_mosi: got %h expected %h", i, s_rx, exp_f); else n_pass++;
      n_checks++; if (rdata !== exp_rd) $display("FAIL rnd%0d_rdata: got %h expected %h", i, rdata, exp_rd); else n_pass++;
      n_checks++; if (s_last_samples != 16) $display("FAIL rnd%0d_samples: got %0d expected 16", i, s_last_samples); else n_pass++;
      m_write(r, a, d);
    end
  endtask

  task automatic test_back_to_back();
    int lat, f0; logic [7:0] exp_rd;
    exp_rd   = m_read(7'd4);
    s_txword = {8'($urandom), exp_rd};
    s_cpha   = 1'b0;
    mode     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    f0 = s_frames;
    rw = 1'b0; addr = 7'd4; wdata = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while ((done !== 1'b1) && (lat < 600)) begin
      start = (lat == 50);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_done_start: busy got %b expected 0", busy); else n_pass++;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (lat != LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_checks++; if (s_frames - f0 != 1) $display("FAIL b2b_frames: got %0d expected 1", s_frames - f0); else n_pass++;
    n_checks++; if ((busy !== 1'b0) || (spi_cs_n !== 1'b1)) $display("FAIL b2b_idle: busy %b cs_n %b expected 0/1", busy, spi_cs_n); else n_pass++;
    n_checks++; if (rdata !== exp_rd) $display("FAIL b2b_rdata: got %h expected %h", rdata, exp_rd); else n_pass++;
  endtask

  task automatic test_ena_stall();
    int lat; logic [7:0] exp_rd; logic t1; logic [7:0] d;
    d = 8'($urandom);
    do_frame(2'b00, 1'b1, 7'd5, d, 40, 20, lat, exp_rd, t1);
    n_checks++; if (lat != LAT + 20) $display("FAIL stall_latency: got %0d expected %0d", lat, LAT + 20); else n_pass++;
    n_checks++; if (s_rx !== {1'b1, 7'd5, d}) $display("FAIL stall_mosi: got %h expected %h", s_rx, {1'b1, 7'd5, d}); else n_pass++;
    n_checks++; if (rdata !== exp_rd) $display("FAIL stall_rdata: got %h expected %h", rdata, exp_rd); else n_pass++;
    m_write(1'b1, 7'd5, d);
  endtask

  task automatic test_reset_mid_frame();
    int lat; logic [7:0] exp_rd; logic t1; logic saw_done;
    saw_done = 1'b0;
    s_txword = {8'($urandom), m_read(7'd3)};
    s_cpha   = 1'b0;
    mode     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rw = 1'b1; addr = 7'd3; wdata = 8'h5A; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    #2 rstb = 1'b0;
    #1;
    n_checks++; if (spi_cs_n !== 1'b1) $display("FAIL midrst_cs_async: got %b expected 1", spi_cs_n); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rstb = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) $display("FAIL midrst_no_done: got %b expected 0", saw_done); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL midrst_rdata: got %h expected 00", rdata); else n_pass++;
    do_frame(2'b00, 1'b0, 7'd3, 8'h00, 0, 0, lat, exp_rd, t1);
    n_checks++; if (lat != LAT) $display("FAIL midrst_next_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_checks++; if (s_rx !== 16'h0300) $display("FAIL midrst_next_mosi: got %h expected 0300", s_rx); else n_pass++;
    n_checks++; if (rdata !== exp_rd) $display("FAIL midrst_next_rdata: got %h expected %h", rdata, exp_rd); else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_mode0();
    test_modes();
    test_loopback();
    test_random();
    test_back_to_back();
    test_ena_stall();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
